// File: rtl/prop_delay_meter.sv
// Propagation-delay meter: watches a gate's input (stim) and output (resp),
// times each stim edge until resp reaches the expected level, and reports
// the delay in clock cycles. Timeout and overrun are sticky flags.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | no measurement in flight; waiting for a stim edge
//  ST_WAIT | stim edge seen, counting cycles until the expected resp edge
module prop_delay_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter bit INVERT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stim,
    input  logic             resp,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] tplh,
    output logic [CNT_W-1:0] tphl,
    output logic             meas_valid,
    output logic             meas_dir,
    output logic             busy,
    output logic             timeout,
    output logic             overrun
);

    // The counter must be able to hold TIMEOUT, and a zero timeout is meaningless.
    if (TIMEOUT < 1 || (64'(TIMEOUT) >> CNT_W) != 0) begin : g_bad_param
        $error("prop_delay_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stim_q;
    logic             resp_q;
    logic             exp_q;
    logic [CNT_W-1:0] tplh_q;
    logic [CNT_W-1:0] tphl_q;
    logic             meas_valid_q;
    logic             meas_dir_q;
    logic             timeout_q;
    logic             overrun_q;

    logic stim_edge;
    logic resp_edge;
    logic exp_d;
    logic hit_now;
    logic hit_wait;

    // Edge detection against last cycle's samples; exp_d is the level the
    // gate should settle to for the stim value seen this cycle.
    always_comb begin
        stim_edge = stim ^ stim_q;
        resp_edge = resp ^ resp_q;
        exp_d     = INVERT ? ~stim : stim;
        hit_now   = resp_edge && (resp == exp_d);
        hit_wait  = resp_edge && (resp == exp_q);
    end

    // Measurement FSM with registered results and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stim_q       <= 1'b0;
            resp_q       <= 1'b0;
            exp_q        <= 1'b0;
            tplh_q       <= '0;
            tphl_q       <= '0;
            meas_valid_q <= 1'b0;
            meas_dir_q   <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            stim_q       <= stim;
            resp_q       <= resp;
            meas_valid_q <= 1'b0;
            // Clearing first lets a same-cycle set below take priority.
            if (clr) begin
                timeout_q <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (!en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (stim_edge) begin
                            if (hit_now) begin
                                if (exp_d) tplh_q <= '0;
                                else       tphl_q <= '0;
                                meas_dir_q   <= exp_d;
                                meas_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                                cnt_q   <= CNT_W'(1);
                                exp_q   <= exp_d;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (stim_edge) begin
                            // A fresh stim edge restarts timing even if resp matched.
                            overrun_q <= 1'b1;
                            cnt_q     <= CNT_W'(1);
                            exp_q     <= exp_d;
                        end else if (hit_wait) begin
                            if (exp_q) tplh_q <= cnt_q;
                            else       tphl_q <= cnt_q;
                            meas_dir_q   <= exp_q;
                            meas_valid_q <= 1'b1;
                            state_q      <= ST_IDLE;
                            cnt_q        <= '0;
                        end else if (cnt_q == TIMEOUT_C) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign tplh       = tplh_q;
    assign tphl       = tphl_q;
    assign meas_valid = meas_valid_q;
    assign meas_dir   = meas_dir_q;
    assign busy       = (state_q == ST_WAIT);
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_prop_delay_meter.sv
// Bench for prop_delay_meter: directed scenarios followed by random stimulus,
// compared cycle by cycle against a timestamp-based reference model.
module tb_prop_delay_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;
    localparam bit INVERT  = 1'b1;

    logic             clk;
    logic             reset;
    logic             stim;
    logic             resp;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] tplh;
    logic [CNT_W-1:0] tphl;
    logic             meas_valid;
    logic             meas_dir;
    logic             busy;
    logic             timeout;
    logic             overrun;

    prop_delay_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .INVERT (INVERT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stim      (stim),
        .resp      (resp),
        .en        (en),
        .clr       (clr),
        .tplh      (tplh),
        .tphl      (tphl),
        .meas_valid(meas_valid),
        .meas_dir  (meas_dir),
        .busy      (busy),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a measurement is a start timestamp plus an expected level.
    int cyc;
    bit m_active;
    int m_start;
    bit m_exp;
    bit m_prev_stim, m_prev_resp;
    int m_tplh, m_tphl;
    bit m_valid, m_dir, m_timeout, m_overrun;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_active = 0; m_start = 0; m_exp = 0;
        m_prev_stim = 0; m_prev_resp = 0;
        m_tplh = 0; m_tphl = 0;
        m_valid = 0; m_dir = 0; m_timeout = 0; m_overrun = 0;
    endtask

    task automatic model_record(input int d, input bit lvl);
        if (lvl) m_tplh = d;
        else     m_tphl = d;
        m_dir   = lvl;
        m_valid = 1;
    endtask

    // One clock edge of the model given the inputs presented before it.
    task automatic model_edge(input bit s, input bit r, input bit e, input bit c);
        bit se, re, want;
        int d;
        se = (s != m_prev_stim);
        re = (r != m_prev_resp);
        want = INVERT ? !s : s;
        m_valid = 0;
        if (c) begin
            m_timeout = 0;
            m_overrun = 0;
        end
        if (!e) begin
            m_active = 0;
        end else if (se) begin
            if (m_active) begin
                m_overrun = 1;
                m_start = cyc;
                m_exp = want;
            end else if (re && r == want) begin
                model_record(0, want);
            end else begin
                m_active = 1;
                m_start = cyc;
                m_exp = want;
            end
        end else if (m_active) begin
            d = cyc - m_start;
            if (re && r == m_exp) begin
                model_record(d, m_exp);
                m_active = 0;
            end else if (d >= TIMEOUT) begin
                m_timeout = 1;
                m_active = 0;
            end
        end
        m_prev_stim = s;
        m_prev_resp = r;
        cyc++;
    endtask

    task automatic check_all();
        chk("busy",       32'(busy),       32'(m_active));
        chk("meas_valid", 32'(meas_valid), 32'(m_valid));
        chk("meas_dir",   32'(meas_dir),   32'(m_dir));
        chk("tplh",       32'(tplh),       32'(m_tplh));
        chk("tphl",       32'(tphl),       32'(m_tphl));
        chk("timeout",    32'(timeout),    32'(m_timeout));
        chk("overrun",    32'(overrun),    32'(m_overrun));
    endtask

    task automatic step(input bit s, input bit r, input bit e = 1'b1, input bit c = 1'b0);
        @(negedge clk);
        stim = s; resp = r; en = e; clr = c;
        model_edge(s, r, e, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tplh"},    32'(tplh),       0);
        chk({tag, "_tphl"},    32'(tphl),       0);
        chk({tag, "_valid"},   32'(meas_valid), 0);
        chk({tag, "_dir"},     32'(meas_dir),   0);
        chk({tag, "_busy"},    32'(busy),       0);
        chk({tag, "_timeout"}, 32'(timeout),    0);
        chk({tag, "_overrun"}, 32'(overrun),    0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        stim = 0; resp = 0; clr = 0; en = 1;
        #2 reset = 1;
        #1 check_zero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    bit cs, cr;

    initial begin
        reset = 1; stim = 0; resp = 0; en = 1; clr = 0;
        model_reset();
        #1 check_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;

        // Gate settles high (resp edge in IDLE is ignored), then stim rises.
        step(0, 1); step(0, 1);
        step(1, 1);
        chk("d1_busy_c0", 32'(busy), 1);
        step(1, 1); step(1, 1);
        step(1, 0);
        chk("d1_tphl", 32'(tphl), 3);
        chk("d1_dir", 32'(meas_dir), 0);
        chk("d1_valid", 32'(meas_valid), 1);
        chk("d1_busy_c3", 32'(busy), 0);
        step(1, 0);
        chk("d1_valid_gone", 32'(meas_valid), 0);

        // Response in the same cycle as stim.
        step(0, 1);
        chk("d2_tplh", 32'(tplh), 0);
        chk("d2_dir", 32'(meas_dir), 1);
        chk("d2_busy", 32'(busy), 0);
        chk("d2_valid", 32'(meas_valid), 1);

        // Timeout after TIMEOUT wait cycles, then clr.
        step(1, 1);
        repeat (TIMEOUT - 1) step(1, 1);
        chk("d3_no_timeout_yet", 32'(timeout), 0);
        step(1, 1);
        chk("d3_timeout", 32'(timeout), 1);
        chk("d3_valid", 32'(meas_valid), 0);
        step(1, 1, 1, 1);
        chk("d3_cleared", 32'(timeout), 0);

        // Overrun: second stim edge two cycles later, resp four cycles after.
        step(0, 1); step(0, 1);
        step(1, 1);
        step(1, 1); step(1, 1); step(1, 1);
        step(1, 0);
        chk("d4_overrun", 32'(overrun), 1);
        chk("d4_tphl", 32'(tphl), 4);
        step(1, 0, 1, 1);
        chk("d4_cleared", 32'(overrun), 0);

        // Glitch to the wrong level, then the right edge at cycle 5.
        do_reset("rst1");
        step(1, 0); step(1, 0);
        step(1, 1); step(1, 1); step(1, 1);
        step(1, 0);
        chk("d5_tphl", 32'(tphl), 5);
        chk("d5_valid", 32'(meas_valid), 1);

        // Reset in the middle of a measurement, then measure again.
        step(0, 0); step(0, 0);
        chk("d6_busy", 32'(busy), 1);
        do_reset("rst2");
        step(1, 0); step(1, 1); step(1, 0);
        chk("d6_tphl", 32'(tphl), 2);

        // en low aborts a measurement.
        step(0, 0); step(0, 0, 0);
        chk("d7_busy", 32'(busy), 0);
        step(0, 1);
        chk("d7_valid", 32'(meas_valid), 0);

        // Random traffic against the model.
        cs = stim; cr = resp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(249) == 0) begin
                do_reset("rst_rand");
                cs = 0; cr = 0;
            end
            if ($urandom_range(5) == 0) cs = ~cs;
            if ($urandom_range(3) == 0) cr = ~cr;
            step(cs, cr, $urandom_range(39) != 0, $urandom_range(24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
